// File: rtl/riscv_core_decode_stage_pkg.sv
// Shared decode types: opcode constants, the 17-bit control word and AMO funct5 legality.
package riscv_core_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_RW     = 7'b0111011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_IW     = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_AMO    = 7'b0101111;

  typedef struct packed {
    logic       regwrite;
    logic [2:0] imsrc;
    logic       uctrl;
    logic       alusrcb;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       aluop;
    logic [1:0] size;
    logic       ldext;
    logic       isword;
    logic       jump;
    logic       bjreg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic amo_f5_legal(input logic [4:0] f5);
    case (f5)
      5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
      5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_core_decode_stage_if.sv
// Fetch->decode->execute handshake bundle; slave is the decode stage, master the surroundings.
interface riscv_core_decode_stage_if #(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 16
);
  import riscv_core_pkg::*;

  logic                   i_decode_stage_valid;
  logic                   o_decode_stage_ready;
  logic [31:0]            i_decode_stage_instr;
  logic [XLEN-1:0]        i_decode_stage_pc;
  logic                   i_decode_stage_flush;
  logic                   o_decode_stage_valid;
  logic                   i_decode_stage_ready;
  logic [XLEN-1:0]        o_decode_stage_pc;
  logic [4:0]             o_decode_stage_rd;
  logic [4:0]             o_decode_stage_rs1;
  logic [4:0]             o_decode_stage_rs2;
  logic [2:0]             o_decode_stage_funct3;
  logic                   o_decode_stage_funct7b5;
  ctrl_t                  o_decode_stage_ctrl;
  logic                   o_decode_stage_illegal;
  logic [STALL_CNT_W-1:0] o_decode_stage_stall_cnt;

  modport slave (
    input  i_decode_stage_valid, i_decode_stage_instr, i_decode_stage_pc,
           i_decode_stage_flush, i_decode_stage_ready,
    output o_decode_stage_ready, o_decode_stage_valid, o_decode_stage_pc,
           o_decode_stage_rd, o_decode_stage_rs1, o_decode_stage_rs2,
           o_decode_stage_funct3, o_decode_stage_funct7b5, o_decode_stage_ctrl,
           o_decode_stage_illegal, o_decode_stage_stall_cnt
  );

  modport master (
    output i_decode_stage_valid, i_decode_stage_instr, i_decode_stage_pc,
           i_decode_stage_flush, i_decode_stage_ready,
    input  o_decode_stage_ready, o_decode_stage_valid, o_decode_stage_pc,
           o_decode_stage_rd, o_decode_stage_rs1, o_decode_stage_rs2,
           o_decode_stage_funct3, o_decode_stage_funct7b5, o_decode_stage_ctrl,
           o_decode_stage_illegal, o_decode_stage_stall_cnt
  );
endinterface

// File: rtl/riscv_core_decode_comb.sv
// Pure combinational main decoder: instr -> {ctrl, illegal}, RV32/RV64 by XLEN.
// AMO opcode decodes only when RISCV_CORE_DECODE_ATOMIC_EN is defined.
module riscv_core_decode_comb
  import riscv_core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);
  localparam bit RV64 = (XLEN == 64);

  logic [6:0] opc;
  logic [2:0] f3;
  ctrl_t      c;
  logic       ill;
  logic       unused_bits;

  assign opc         = instr_i[6:0];
  assign f3          = instr_i[14:12];
  assign unused_bits = ^{instr_i[31:15], instr_i[11:7]};

  // opcode[1:0] is part of every match, so a non-11 low pair lands in default
  always_comb begin
    c   = CTRL_NOP;
    ill = 1'b0;
    case (opc)
      OP_R, OP_RW: begin
        c.regwrite = 1'b1;
        c.aluop    = 1'b1;
        c.isword   = (opc == OP_RW);
        ill        = (opc == OP_RW) && !RV64;
      end
      OP_I, OP_IW: begin
        c.regwrite = 1'b1;
        c.aluop    = 1'b1;
        c.alusrcb  = 1'b1;
        c.isword   = (opc == OP_IW);
        ill        = (opc == OP_IW) && !RV64;
      end
      OP_LOAD: begin
        c.regwrite  = 1'b1;
        c.alusrcb   = 1'b1;
        c.resultsrc = 2'b01;
        c.size      = f3[1:0];
        c.ldext     = f3[2];
        ill         = (f3 == 3'd7) || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
      end
      OP_STORE: begin
        c.imsrc    = 3'b001;
        c.alusrcb  = 1'b1;
        c.memwrite = 1'b1;
        c.size     = f3[1:0];
        ill        = f3[2] || (!RV64 && f3 == 3'd3);
      end
      OP_BRANCH: begin
        c.imsrc   = 3'b010;
        c.alusrcb = 1'b1;
        c.branch  = 1'b1;
        ill       = (f3[2:1] == 2'b01);
      end
      OP_JAL: begin
        c.regwrite  = 1'b1;
        c.imsrc     = 3'b011;
        c.alusrcb   = 1'b1;
        c.resultsrc = 2'b10;
        c.jump      = 1'b1;
      end
      OP_JALR: begin
        c.regwrite  = 1'b1;
        c.alusrcb   = 1'b1;
        c.resultsrc = 2'b10;
        c.jump      = 1'b1;
        c.bjreg     = 1'b1;
        ill         = (f3 != 3'd0);
      end
      OP_LUI, OP_AUIPC: begin
        c.regwrite  = 1'b1;
        c.imsrc     = 3'b100;
        c.uctrl     = (opc == OP_LUI);
        c.alusrcb   = 1'b1;
        c.resultsrc = 2'b11;
      end
`ifdef RISCV_CORE_DECODE_ATOMIC_EN
      OP_AMO: begin
        c.regwrite  = 1'b1;
        c.memwrite  = 1'b1;
        c.resultsrc = 2'b01;
        c.size      = f3[1:0];
        c.isword    = (f3 == 3'b010);
        ill         = !((f3 == 3'b010) || (RV64 && f3 == 3'b011)) ||
                      !amo_f5_legal(instr_i[31:27]);
      end
`endif
      default: ill = 1'b1;
    endcase
  end

  assign ctrl_o    = ill ? CTRL_NOP : c;
  assign illegal_o = ill;

endmodule

// File: rtl/riscv_core_decode_stage.sv
// Registered decode stage: decoder feeding an output register backed by one skid entry.
// Optional AMO decode is enabled by defining RISCV_CORE_DECODE_ATOMIC_EN.
module riscv_core_decode_stage
  import riscv_core_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int STALL_CNT_W = 16
) (
  input logic                      i_decode_stage_clk,
  input logic                      i_decode_stage_rst_n,
  riscv_core_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      f3;
    logic            f7b5;
    ctrl_t           ctrl;
    logic            illegal;
  } entry_t;

  ctrl_t                  dec_ctrl;
  logic                   dec_illegal;
  entry_t                 in_e, out_q, out_d, skid_q, skid_d;
  logic                   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   accept, blocked;

  riscv_core_decode_comb #(.XLEN(XLEN)) u_comb (
    .instr_i   (bus.i_decode_stage_instr),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  assign in_e = {bus.i_decode_stage_pc, bus.i_decode_stage_instr[11:7],
                 bus.i_decode_stage_instr[19:15], bus.i_decode_stage_instr[24:20],
                 bus.i_decode_stage_instr[14:12], bus.i_decode_stage_instr[30],
                 dec_ctrl, dec_illegal};

  // ready depends only on skid state, so i_ready never reaches o_ready combinationally
  assign accept  = bus.i_decode_stage_valid && !skid_vld_q && !bus.i_decode_stage_flush;
  assign blocked = out_vld_q && !bus.i_decode_stage_ready;

  always_comb begin
    out_d      = out_q;
    skid_d     = skid_q;
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (bus.i_decode_stage_flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (blocked) begin
      if (accept) begin
        skid_d     = in_e;
        skid_vld_d = 1'b1;
      end
    end else if (skid_vld_q) begin
      out_d      = skid_q;
      out_vld_d  = 1'b1;
      skid_vld_d = 1'b0;
    end else begin
      out_vld_d = accept;
      if (accept) out_d = in_e;
    end
  end

  assign stall_d = (blocked && stall_q != '1) ? stall_q + STALL_CNT_W'(1) : stall_q;

  always_ff @(posedge i_decode_stage_clk or negedge i_decode_stage_rst_n) begin
    if (!i_decode_stage_rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      stall_q    <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      stall_q    <= stall_d;
    end
  end

  assign bus.o_decode_stage_ready     = !skid_vld_q;
  assign bus.o_decode_stage_valid     = out_vld_q;
  assign bus.o_decode_stage_pc        = out_q.pc;
  assign bus.o_decode_stage_rd        = out_q.rd;
  assign bus.o_decode_stage_rs1       = out_q.rs1;
  assign bus.o_decode_stage_rs2       = out_q.rs2;
  assign bus.o_decode_stage_funct3    = out_q.f3;
  assign bus.o_decode_stage_funct7b5  = out_q.f7b5;
  assign bus.o_decode_stage_ctrl      = out_q.ctrl;
  assign bus.o_decode_stage_illegal   = out_q.illegal;
  assign bus.o_decode_stage_stall_cnt = stall_q;

endmodule

// File: tb/tb_riscv_core_decode_stage.sv
// Scoreboard bench: an RV64 stage (4-bit stall counter) and an RV32 stage on one clock.
module tb_riscv_core_decode_stage;
  import riscv_core_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_core_decode_stage_if #(.XLEN(64), .STALL_CNT_W(4))  b64 ();
  riscv_core_decode_stage_if #(.XLEN(32), .STALL_CNT_W(16)) b32 ();

  riscv_core_decode_stage #(.XLEN(64), .STALL_CNT_W(4)) u_dut64 (
    .i_decode_stage_clk(clk), .i_decode_stage_rst_n(rst_n), .bus(b64));
  riscv_core_decode_stage #(.XLEN(32), .STALL_CNT_W(16)) u_dut32 (
    .i_decode_stage_clk(clk), .i_decode_stage_rst_n(rst_n), .bus(b32));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // returns {illegal, ctrl}; codes are {regwrite,imsrc,UCtrl,alusrcB,memwrite,resultsrc,branch,aluop,jump,bjreg}
  function automatic logic [17:0] ref_dec(input logic [31:0] ins, input bit rv64);
    logic [12:0] code;
    logic [1:0]  sz;
    logic [2:0]  f3;
    logic        ldx, isw, bad;
    f3 = ins[14:12];
    code = '0; sz = '0; ldx = 1'b0; isw = 1'b0; bad = 1'b0;
    case (ins[6:0])
      7'b0110011: code = 13'b1_000_0_0_0_00_0_1_0_0;
      7'b0111011: begin code = 13'b1_000_0_0_0_00_0_1_0_0; isw = 1'b1; bad = !rv64; end
      7'b0010011: code = 13'b1_000_0_1_0_00_0_1_0_0;
      7'b0011011: begin code = 13'b1_000_0_1_0_00_0_1_0_0; isw = 1'b1; bad = !rv64; end
      7'b0000011: begin
        code = 13'b1_000_0_1_0_01_0_0_0_0; sz = f3[1:0]; ldx = f3[2];
        bad = (f3 == 7) || (!rv64 && (f3 == 3 || f3 == 6));
      end
      7'b0100011: begin
        code = 13'b0_001_0_1_1_00_0_0_0_0; sz = f3[1:0];
        bad = (f3 > 3) || (!rv64 && f3 == 3);
      end
      7'b1100011: begin code = 13'b0_010_0_1_0_00_1_0_0_0; bad = (f3 == 2 || f3 == 3); end
      7'b1101111: code = 13'b1_011_0_1_0_10_0_0_1_0;
      7'b1100111: begin code = 13'b1_000_0_1_0_10_0_0_1_1; bad = (f3 != 0); end
      7'b0110111: code = 13'b1_100_1_1_0_11_0_0_0_0;
      7'b0010111: code = 13'b1_100_0_1_0_11_0_0_0_0;
`ifdef RISCV_CORE_DECODE_ATOMIC_EN
      7'b0101111: begin
        code = 13'b1_000_0_0_1_01_0_0_0_0; sz = f3[1:0]; isw = (f3 == 3'b010);
        bad = !(f3 == 3'b010 || (rv64 && f3 == 3'b011)) ||
              !(ins[31:27] inside {5'b00010, 5'b00011, 5'b00001, 5'b00000, 5'b00100, 5'b01100,
                                   5'b01000, 5'b10000, 5'b10100, 5'b11000, 5'b11100});
      end
`endif
      default: bad = 1'b1;
    endcase
    if (bad) return {1'b1, 17'b0};
    return {1'b0, code[12:2], sz, ldx, isw, code[1:0]};
  endfunction

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t       sb[$];
  int         n_out64 = 0;
  logic [3:0] exp_stall = '0;

  // monitor for the RV64 stage: pop on consume, push on accept, track stall counter
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      exp_stall = '0;
    end else begin
      chk("stall_cnt", 64'(b64.o_decode_stage_stall_cnt), 64'(exp_stall));
      if (b64.o_decode_stage_valid && !b64.i_decode_stage_ready && exp_stall != 4'hF)
        exp_stall = exp_stall + 4'd1;
      if (b64.o_decode_stage_valid && b64.i_decode_stage_ready) begin
        n_out64++;
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t       e;
          logic [17:0] r;
          e = sb.pop_front();
          r = ref_dec(e.instr, 1'b1);
          chk("out_pc",      b64.o_decode_stage_pc, e.pc);
          chk("out_rd",      64'(b64.o_decode_stage_rd),     64'(e.instr[11:7]));
          chk("out_rs1",     64'(b64.o_decode_stage_rs1),    64'(e.instr[19:15]));
          chk("out_rs2",     64'(b64.o_decode_stage_rs2),    64'(e.instr[24:20]));
          chk("out_funct3",  64'(b64.o_decode_stage_funct3), 64'(e.instr[14:12]));
          chk("out_f7b5",    64'(b64.o_decode_stage_funct7b5), 64'(e.instr[30]));
          chk("out_ctrl",    64'(b64.o_decode_stage_ctrl),   64'(r[16:0]));
          chk("out_illegal", 64'(b64.o_decode_stage_illegal), 64'(r[17]));
        end
      end
      if (b64.i_decode_stage_flush) sb.delete();
      else if (b64.i_decode_stage_valid && b64.o_decode_stage_ready)
        sb.push_back('{pc: b64.i_decode_stage_pc, instr: b64.i_decode_stage_instr});
    end
  end

  task automatic drv64(input logic [31:0] ins, input logic [63:0] pc);
    b64.i_decode_stage_valid = 1'b1;
    b64.i_decode_stage_instr = ins;
    b64.i_decode_stage_pc    = pc;
    @(posedge clk); #1;
  endtask

  task automatic idle64(input int n);
    b64.i_decode_stage_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] stream [14] = '{32'h00B50533, 32'h00053583, 32'h00B53023, 32'h00000000,
                               32'h00057583, 32'h00B52063, 32'h000510E7, 32'h00B5252F,
                               32'h123452B7, 32'h008000EF, 32'h00001517, 32'h0015051B,
                               32'h00B50663, 32'h000500E7};
  logic [31:0] rv32_set [6] = '{32'h00B5053B, 32'h00056583, 32'h00B53023,
                                32'h00B50533, 32'h0005A583, 32'h00B5352F};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n0;
    logic [17:0] r;
    b64.i_decode_stage_valid = 1'b0; b64.i_decode_stage_instr = '0; b64.i_decode_stage_pc = '0;
    b64.i_decode_stage_flush = 1'b0; b64.i_decode_stage_ready = 1'b1;
    b32.i_decode_stage_valid = 1'b0; b32.i_decode_stage_instr = '0; b32.i_decode_stage_pc = '0;
    b32.i_decode_stage_flush = 1'b0; b32.i_decode_stage_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid",   64'(b64.o_decode_stage_valid), 64'd0);
    chk("rst_pc",      b64.o_decode_stage_pc, 64'd0);
    chk("rst_ctrl",    64'(b64.o_decode_stage_ctrl), 64'd0);
    chk("rst_illegal", 64'(b64.o_decode_stage_illegal), 64'd0);
    chk("rst_stall",   64'(b64.o_decode_stage_stall_cnt), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 64'(b64.o_decode_stage_ready), 64'd1);

    // back-to-back stream with downstream always ready
    n0 = n_out64;
    for (int k = 0; k < 14; k++) begin
      drv64(stream[k], 64'h1000 + 64'(4 * k));
      if (k == 0) begin
        chk("lat1_valid", 64'(b64.o_decode_stage_valid), 64'd1);
        chk("lat1_pc",    b64.o_decode_stage_pc, 64'h1000);
      end
      if (k == 1) begin
        chk("ld_resultsrc", 64'(b64.o_decode_stage_ctrl.resultsrc), 64'd1);
        chk("ld_size",      64'(b64.o_decode_stage_ctrl.size), 64'd3);
        chk("ld_ldext",     64'(b64.o_decode_stage_ctrl.ldext), 64'd0);
      end
    end
    idle64(1);
    chk("stream_throughput", 64'(n_out64 - n0), 64'd14);
    idle64(2);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // backpressure: first held, second skidded, third refused
    b64.i_decode_stage_ready = 1'b0;
    n0 = n_out64;
    drv64(32'h00B50533, 64'h2000);
    chk("bp_ready_1", 64'(b64.o_decode_stage_ready), 64'd1);
    drv64(32'h00053583, 64'h2004);
    chk("bp_ready_0", 64'(b64.o_decode_stage_ready), 64'd0);
    drv64(32'h00B53023, 64'h2008);
    chk("bp_ready_held", 64'(b64.o_decode_stage_ready), 64'd0);
    chk("bp_head_pc",    b64.o_decode_stage_pc, 64'h2000);
    b64.i_decode_stage_ready = 1'b1;
    idle64(1);
    chk("bp_skid_moved_pc", b64.o_decode_stage_pc, 64'h2004);
    chk("bp_ready_back",    64'(b64.o_decode_stage_ready), 64'd1);
    idle64(3);
    chk("bp_out_count", 64'(n_out64 - n0), 64'd2);
    chk("bp_drained",   64'(sb.size()), 64'd0);

    // flush with both entries full and a new input presented
    b64.i_decode_stage_ready = 1'b0;
    n0 = n_out64;
    drv64(32'h00B50533, 64'h3000);
    drv64(32'h00053583, 64'h3004);
    chk("fl_full_ready", 64'(b64.o_decode_stage_ready), 64'd0);
    b64.i_decode_stage_flush = 1'b1;
    drv64(32'h00B53023, 64'h3008);
    b64.i_decode_stage_flush = 1'b0;
    b64.i_decode_stage_valid = 1'b0;
    chk("fl_valid", 64'(b64.o_decode_stage_valid), 64'd0);
    chk("fl_ready", 64'(b64.o_decode_stage_ready), 64'd1);
    b64.i_decode_stage_ready = 1'b1;
    // flush on an empty, ready stage still drops the presented input
    b64.i_decode_stage_flush = 1'b1;
    drv64(32'h00B50533, 64'h3010);
    b64.i_decode_stage_flush = 1'b0;
    b64.i_decode_stage_valid = 1'b0;
    chk("fl2_valid", 64'(b64.o_decode_stage_valid), 64'd0);
    idle64(3);
    chk("fl_no_output", 64'(n_out64 - n0), 64'd0);

    // stall counter saturation, then async reset mid-cycle
    b64.i_decode_stage_ready = 1'b0;
    drv64(32'h00B50533, 64'h4000);
    idle64(20);
    chk("stall_sat", 64'(b64.o_decode_stage_stall_cnt), 64'd15);
    chk("stall_sat_valid", 64'(b64.o_decode_stage_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stall", 64'(b64.o_decode_stage_stall_cnt), 64'd0);
    chk("midrst_valid", 64'(b64.o_decode_stage_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    b64.i_decode_stage_ready = 1'b1;
    idle64(1);

    // AMO word op on RV64
    drv64(32'h00B5252F, 64'h5000);
`ifdef RISCV_CORE_DECODE_ATOMIC_EN
    chk("amo_illegal",  64'(b64.o_decode_stage_illegal), 64'd0);
    chk("amo_memwrite", 64'(b64.o_decode_stage_ctrl.memwrite), 64'd1);
    chk("amo_isword",   64'(b64.o_decode_stage_ctrl.isword), 64'd1);
`else
    chk("amo_illegal",  64'(b64.o_decode_stage_illegal), 64'd1);
    chk("amo_ctrl",     64'(b64.o_decode_stage_ctrl), 64'd0);
`endif
    idle64(2);

    // RV32 stage: word ops and 64-bit memory ops must trap but still be delivered
    for (int k = 0; k < 6; k++) begin
      b32.i_decode_stage_valid = 1'b1;
      b32.i_decode_stage_instr = rv32_set[k];
      b32.i_decode_stage_pc    = 32'h10 + 32'(4 * k);
      @(posedge clk); #1;
      r = ref_dec(rv32_set[k], 1'b0);
      chk("rv32_valid",   64'(b32.o_decode_stage_valid), 64'd1);
      chk("rv32_pc",      64'(b32.o_decode_stage_pc), 64'h10 + 64'(4 * k));
      chk("rv32_ctrl",    64'(b32.o_decode_stage_ctrl), 64'(r[16:0]));
      chk("rv32_illegal", 64'(b32.o_decode_stage_illegal), 64'(r[17]));
      if (k < 2) chk("rv32_trap", 64'(b32.o_decode_stage_illegal), 64'd1);
    end
    b32.i_decode_stage_valid = 1'b0;
    @(posedge clk); #1;
    chk("rv32_idle_valid", 64'(b32.o_decode_stage_valid), 64'd0);
    chk("rv32_stall",      64'(b32.o_decode_stage_stall_cnt), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_core_decode_stage.md
Name: riscv_core_decode_stage

Overview:
Registered, parametrised main-decode pipeline stage between fetch and execute.
- Decodes a 32-bit instruction into the core control word and register fields, for RV32 or RV64 selected by parameter.
- Flags illegal encodings and holds results behind a valid/ready handshake with a 2-entry skid buffer.
- Supports pipeline flush and keeps a saturating backpressure-cycle counter.

Parameters:
XLEN, 64, datapath/PC width; legal values 32 or 64. At 32, word-op opcodes and 64-bit loads/stores are illegal.
STALL_CNT_W, 16, width of the backpressure counter.

Ports:
i_decode_stage_clk  in  1  clock.
i_decode_stage_rst_n  in  1  asynchronous active-low reset.
i_decode_stage_valid  in  1  upstream instruction valid.
o_decode_stage_ready  out  1  stage can accept.
i_decode_stage_instr  in  32  instruction word.
i_decode_stage_pc  in  XLEN  instruction PC.
i_decode_stage_flush  in  1  kill all held and incoming entries.
o_decode_stage_valid  out  1  decoded entry valid.
i_decode_stage_ready  in  1  downstream accepts.
o_decode_stage_pc  out  XLEN  registered PC.
o_decode_stage_rd/rs1/rs2  out  5 each  instr[11:7], [19:15], [24:20].
o_decode_stage_funct3  out  3  instr[14:12].
o_decode_stage_funct7b5  out  1  instr[30].
o_decode_stage_ctrl  out  17  control word {regwrite, imsrc[2:0], UCtrl, alusrcB, memwrite, resultsrc[1:0], branch, aluop, size[1:0], LdExt, isword, jump, bjreg}.
o_decode_stage_illegal  out  1  entry is an illegal instruction.
o_decode_stage_stall_cnt  out  STALL_CNT_W  saturating count of cycles with o_valid=1 and i_ready=0.

Behaviour:
- Reset (async assert, sync release): both entries invalid, all outputs 0, o_ready=1 from the first cycle after release.
- Control word per opcode (regwrite/imsrc/UCtrl/alusrcB/memwrite/resultsrc/branch/aluop/jump/bjreg):
  - R 0110011: 1/000/0/0/0/00/0/1/0/0.
  - R-word 0111011: same as R with isword=1.
  - I 0010011: as R with alusrcB=1.
  - I-word 0011011: as I with isword=1.
  - Load 0000011: 1/000/0/1/0/01/0/0/0/0.
  - Store 0100011: 0/001/0/1/1/00/0/0/0/0.
  - Branch 1100011: 0/010/0/1/0/00/1/0/0/0.
  - JAL 1101111: 1/011/0/1/0/10/0/0/1/0.
  - JALR 1100111: 1/000/0/1/0/10/0/0/1/1.
  - LUI 0110111: 1/100/1/1/0/11/0/0/0/0.
  - AUIPC 0010111: 1/100/0/1/0/11/0/0/0/0.
- Size and LdExt:
  - Loads: size=funct3[1:0], LdExt=funct3[2].
  - Stores: size=funct3[1:0], LdExt=0.
  - All others: size=00, LdExt=0.
- Illegal when any of:
  - instr[1:0]!=11, or opcode not listed.
  - Load funct3=7; at XLEN=32 also funct3 3 or 6.
  - Store funct3>3; at XLEN=32 also funct3=3.
  - Branch funct3 2 or 3; JALR funct3!=0.
  - XLEN=32 and opcode 0111011 or 0011011.
  - Illegal entries: ctrl=0, illegal=1, still delivered with o_valid=1 (trap raised downstream).
- Latency: 1 cycle, accept to o_valid.
- Throughput: 1 per cycle when downstream is ready.
- Handshake: accept when i_valid&&o_ready. Output held stable while o_valid&&!i_ready.
- Skid buffer:
  - o_ready = !skid_valid, registered (no combinational path from i_ready).
  - Accept while output blocked: entry goes to skid. o_ready drops next cycle.
  - Output consumed with skid full: skid moves to output. o_ready=1 next cycle.
  - Simultaneous accept and consume with skid empty: new entry loads output directly.
- Flush dominates everything:
  - Both entries invalid next cycle.
  - Input presented in the flush cycle is not accepted (o_ready still reported, entry dropped).
  - stall_cnt unaffected by flush.
- stall_cnt: +1 each cycle o_valid&&!i_ready, saturates at all-ones, cleared only by reset.
- Reset mid-operation: entries dropped immediately, counter cleared.

Optional Feature:
RISCV_CORE_DECODE_ATOMIC_EN
- Defined: opcode 0101111 (AMO) decodes to 1/000/0/0/1/01/0/0, size=funct3[1:0], LdExt=0, isword=(funct3==010), jump=0, bjreg=0.
  - Legal funct3: 010, and 011 only when XLEN=64.
  - Legal funct5 (instr[31:27]): 00010, 00011, 00001, 00000, 00100, 01100, 01000, 10000, 10100, 11000, 11100.
  - Anything else is illegal.
- Undefined: 0101111 is illegal.

Decomposition:
- Package riscv_core_pkg holds:
  - opcode localparams (OP_R, OP_RW, OP_I, OP_IW, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_AMO);
  - packed struct ctrl_t in the field order above;
  - CTRL_NOP constant.
- Sub-module riscv_core_decode_comb: pure combinational instr -> {ctrl, illegal}, parametrised on XLEN. The stage wraps it with skid/handshake logic.

Test Plan:
- XLEN=64, stream add 0x00B50533, ld 0x00053583, sd 0x00B53023, i_ready=1 -> one output per cycle, 1-cycle latency. Ctrl for ld: resultsrc=01, size=11, LdExt=0.
- XLEN=32, present addw 0x00B5053B, then lwu 0x00056583 -> both o_illegal=1, ctrl=0, o_valid=1.
- Hold i_ready=0 and send 3 instrs -> first held on output, second in skid, o_ready=0, third not accepted. Raise i_ready -> order preserved, no loss or duplicate.
- Two full entries plus flush and i_valid together -> next cycle o_valid=0, o_ready=1, flushed-cycle instr never appears.
- STALL_CNT_W=4, i_ready=0 for 20 cycles with o_valid=1 -> stall_cnt saturates at 15. Assert reset -> 0.
- RISCV_CORE_DECODE_ATOMIC_EN defined: amoadd.w 0x00B5252F -> memwrite=1, isword=1, legal. Undefined -> illegal=1.
